// File: rtl/mult_booth_seq.sv
// Sequential signed multiplier using radix-4 modified Booth recoding.
// A start pulse loads the operands, and WIDTH/2 iterations follow, one per clock.
// Each iteration adds the recoded multiple of M to ACC and then
// arithmetic-shifts {ACC, Q, q_1} right by 2.
// The block returns the low word of the product, a signed-overflow flag and a
// one-cycle ready pulse.
//
// state | meaning
// IDLE  | waiting for ctrl_MULT
// RUN   | Booth iterations in progress (busy=1)
// DONE  | result registered, data_resultRDY high for this one cycle
module mult_booth_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int AW   = WIDTH + 2;
  localparam int ITER = WIDTH / 2;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [AW-1:0]    m;
  logic [AW-1:0]    acc;
  logic [WIDTH-1:0] q;
  logic             q_1;

  logic [AW-1:0]    addend;
  logic [AW-1:0]    acc_sum;
  logic [AW-1:0]    acc_nx;
  logic [WIDTH-1:0] q_nx;
  logic             q_1_nx;
  logic [WIDTH:0]   ovf_bits;
  logic             last_iter;
  logic             ovf_nx;

  // Booth recode, add, and 2-bit arithmetic shift of {ACC, Q, q_1}.
  always_comb begin
    addend = '0;
    case ({q[1:0], q_1})
      3'b001, 3'b010: addend = m;
      3'b011:         addend = {m[AW-2:0], 1'b0};
      3'b100:         addend = -{m[AW-2:0], 1'b0};
      3'b101, 3'b110: addend = -m;
      default:        addend = '0;
    endcase
    acc_sum   = acc + addend;
    acc_nx    = {{2{acc_sum[AW-1]}}, acc_sum[AW-1:2]};
    q_nx      = {acc_sum[1:0], q[WIDTH-1:2]};
    q_1_nx    = q[1];
    // Product bits 2W-1..W-1 must all match for the low word to hold the value.
    ovf_bits  = {acc_nx[WIDTH-1:0], q_nx[WIDTH-1]};
    ovf_nx    = !((&ovf_bits) || !(|ovf_bits));
    last_iter = (count == CW'(ITER - 1));
  end

  // Control FSM and datapath registers; a start pulse has priority over every state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      m              <= '0;
      acc            <= '0;
      q              <= '0;
      q_1            <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_MULT) begin
        state <= RUN;
        busy  <= 1'b1;
        count <= '0;
        m     <= {{2{data_operandA[WIDTH-1]}}, data_operandA};
        acc   <= '0;
        q     <= data_operandB;
        q_1   <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          RUN: begin
            acc   <= acc_nx;
            q     <= q_nx;
            q_1   <= q_1_nx;
            count <= count + CW'(1);
            if (last_iter) begin
              state          <= DONE;
              busy           <= 1'b0;
              data_result    <= q_nx;
              data_exception <= ovf_nx;
              data_resultRDY <= 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
